// File: rtl/gin_id_scan_config_ctrl.sv
// GIN row/column ID scan-chain loader.
// Holds off GIN traffic, waits for the network to drain, then shifts config words
// into the ID chain LSB first while capturing the old chain contents as readback words.
module gin_id_scan_config_ctrl #(
  parameter int ROW_TAG_WIDTH  = 4,
  parameter int COL_TAG_WIDTH  = 4,
  parameter int NUM_OF_ROWS    = 12,
  parameter int NUM_OF_COLS    = 14,
  parameter int CFG_WORD_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      gin_idle,
  output logic                      gin_hold,
  output logic                      busy,
  output logic                      done,
  input  logic [CFG_WORD_WIDTH-1:0] cfg_data,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  output logic [CFG_WORD_WIDTH-1:0] rb_data,
  output logic                      rb_valid,
  input  logic                      rb_ready,
  output logic                      se_id,
  output logic                      si_id,
  input  logic                      so_id
);

  localparam int CHAIN_LEN = NUM_OF_ROWS*ROW_TAG_WIDTH + NUM_OF_ROWS*NUM_OF_COLS*COL_TAG_WIDTH;
  localparam int NUM_WORDS = (CHAIN_LEN + CFG_WORD_WIDTH - 1) / CFG_WORD_WIDTH;
  localparam int LAST_BITS = CHAIN_LEN - (NUM_WORDS-1)*CFG_WORD_WIDTH;
  localparam int BIT_W     = (CFG_WORD_WIDTH > 1) ? $clog2(CFG_WORD_WIDTH) : 1;
  localparam int WORD_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [BIT_W-1:0]  FULL_IDX  = BIT_W'(CFG_WORD_WIDTH - 1);
  localparam logic [BIT_W-1:0]  LAST_IDX  = BIT_W'(LAST_BITS - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_LOAD, S_SHIFT, S_RB, S_DONE} state_t;

  state_t                    state, state_nxt;
  logic [CFG_WORD_WIDTH-1:0] sreg;
  logic [CFG_WORD_WIDTH-1:0] rb_sreg;
  logic [BIT_W-1:0]          bit_idx;
  logic [BIT_W-1:0]          last_idx;   // nbits-1 for the word being shifted
  logic [WORD_W-1:0]         word_cnt;
  logic                      last_bit;

  assign last_bit = (bit_idx == last_idx);
  assign rb_data  = rb_sreg;

  // State register; abort is folded into next-state so it wins everywhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and state-decoded handshake/status outputs.
  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    gin_hold  = (state != S_IDLE);
    cfg_ready = (state == S_LOAD);
    rb_valid  = (state == S_RB);
    done      = (state == S_DONE);
    case (state)
      S_IDLE:  if (start)     state_nxt = S_DRAIN;
      S_DRAIN: if (gin_idle)  state_nxt = S_LOAD;
      S_LOAD:  if (cfg_valid) state_nxt = S_SHIFT;
      S_SHIFT: if (last_bit)  state_nxt = S_RB;
      S_RB:    if (rb_ready)  state_nxt = (word_cnt == LAST_WORD) ? S_DONE : S_LOAD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Shift datapath: se_id/si_id are registered so se_id is high for exactly the
  // SHIFT cycles, and si_id always presents the next unshifted config bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg     <= '0;
      rb_sreg  <= '0;
      bit_idx  <= '0;
      last_idx <= '0;
      word_cnt <= '0;
      se_id    <= 1'b0;
      si_id    <= 1'b0;
    end else if (abort) begin
      bit_idx  <= '0;
      word_cnt <= '0;
      se_id    <= 1'b0;
      si_id    <= 1'b0;
    end else begin
      case (state)
        S_LOAD: if (cfg_valid) begin
          sreg     <= cfg_data >> 1;
          si_id    <= cfg_data[0];
          se_id    <= 1'b1;
          bit_idx  <= '0;
          rb_sreg  <= '0;   // unused upper bits of a short word read back as 0
          last_idx <= (word_cnt == LAST_WORD) ? LAST_IDX : FULL_IDX;
        end
        S_SHIFT: begin
          rb_sreg[bit_idx] <= so_id;
          if (last_bit) begin
            se_id <= 1'b0;
            si_id <= 1'b0;
          end else begin
            si_id   <= sreg[0];
            sreg    <= sreg >> 1;
            bit_idx <= bit_idx + 1'b1;
          end
        end
        S_RB: if (rb_ready && word_cnt != LAST_WORD) word_cnt <= word_cnt + 1'b1;
        S_DONE: word_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gin_id_scan_config_ctrl.sv
// Bench for gin_id_scan_config_ctrl: a FIFO-style scan-chain model plus word-level
// expectations (readback = previous chain image, new chain image = config stream).
module tb_gin_id_scan_config_ctrl;

  localparam int W         = 32;
  localparam int CHAIN_LEN = 12*4 + 12*14*4;
  localparam int NW        = (CHAIN_LEN + W - 1) / W;
  localparam int LAST_BITS = CHAIN_LEN - (NW-1)*W;
  localparam int MIN_LOAD  = 2 + NW*2 + CHAIN_LEN;

  logic clk = 1'b0;
  logic reset, start, abort, gin_idle, cfg_valid, rb_ready, so_id;
  logic gin_hold, busy, done, cfg_ready, rb_valid, se_id, si_id;
  logic [W-1:0] cfg_data, rb_data;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] words [NW];
  logic [W-1:0] pat_a [NW];
  logic [W-1:0] rbw   [NW];

  // scan chain: bit 0 is the so end, new bits enter at the top
  logic [CHAIN_LEN-1:0] chain;
  logic [CHAIN_LEN-1:0] seed_val;
  logic                 seed_req;
  int                   se_cnt;

  gin_id_scan_config_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .gin_idle(gin_idle),
    .gin_hold(gin_hold), .busy(busy), .done(done),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .rb_data(rb_data), .rb_valid(rb_valid), .rb_ready(rb_ready),
    .se_id(se_id), .si_id(si_id), .so_id(so_id)
  );

  always #5 clk = ~clk;

  assign so_id = chain[0];

  always @(posedge clk) begin
    if (seed_req)   chain <= seed_val;
    else if (se_id) chain <= {si_id, chain[CHAIN_LEN-1:1]};
  end

  always @(posedge clk) if (se_id) se_cnt <= se_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 full load, 1 abort in SHIFT, 2 abort in RB, 3 reset in SHIFT (at stop_word)
  task automatic run_load(input int drain_wait, input int stall_word, input int stall_len,
                          input bit rand_valid, input int mode, input int stop_word);
    logic [CHAIN_LEN-1:0] snap;
    logic [NW*W-1:0]      stream;
    logic [W-1:0]         exp_rb;
    int k, r, se0, waits, stall_left, first_ready, cut;
    bit fin;
    snap = chain; se0 = se_cnt;
    k = 0; r = 0; waits = 0; stall_left = stall_len; first_ready = -1; cut = 0; fin = 0;
    for (int w = 0; w < NW; w++) stream[w*W +: W] = words[w];
    start = 1; abort = 0; gin_idle = 0; cfg_valid = 0; rb_ready = 0;
    for (int n = 1; n <= 6000 && !fin; n++) begin
      @(posedge clk); #1;
      start = 0;
      if (cut == 3) begin
        chk("reset_outputs", {busy, gin_hold, done, cfg_ready, rb_valid, se_id, si_id}, 7'd0);
        chk("reset_rb_data", rb_data, 0);
        reset = 0;
        fin = 1;
      end else if (cut != 0) begin
        abort = 0;
        chk("abort_outputs", {busy, gin_hold, done, cfg_ready, rb_valid, se_id}, 6'd0);
        fin = 1;
      end else if (done) begin
        chk("done_cycle", n, MIN_LOAD + drain_wait + waits);
        chk("cfg_handshakes", k, NW);
        chk("rb_handshakes", r, NW);
        chk("se_cycles", se_cnt - se0, CHAIN_LEN);
        chk("chain_image", chain === stream[CHAIN_LEN-1:0], 1);
        chk("done_busy_hold", {busy, gin_hold}, 2'b11);
        fin = 1;
      end else if ((mode == 1 || mode == 3) && se_id && k == stop_word + 1) begin
        if (mode == 1) begin abort = 1; cut = 1; end
        else begin reset = 1; cut = 3; end
      end else if (mode == 2 && rb_valid && r == stop_word) begin
        abort = 1; cut = 2;
      end else begin
        gin_idle = (n > drain_wait);
        if (n <= drain_wait + 1)
          chk("drain_hold", {gin_hold, cfg_ready, se_id}, 3'b100);
        if (cfg_ready && first_ready < 0) begin
          first_ready = n;
          chk("load_entry", n, drain_wait + 2);
        end
        cfg_data  = (k < NW) ? words[k] : $urandom();
        cfg_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        if (cfg_ready) begin
          if (cfg_valid) k++;
          else waits++;
        end
        if (rb_valid) begin
          if (r == NW-1) exp_rb = {{(W-LAST_BITS){1'b0}}, snap[CHAIN_LEN-1 -: LAST_BITS]};
          else           exp_rb = snap[r*W +: W];
          chk("rb_data", rb_data, exp_rb);
          chk("rb_exclusive", {se_id, cfg_ready}, 2'b00);
          if (r == stall_word && stall_left > 0) begin
            rb_ready = 0; stall_left--; waits++;
          end else begin
            rb_ready = 1; rbw[r] = rb_data; r++;
          end
        end else begin
          rb_ready = 1'($urandom_range(0, 1));
        end
      end
    end
    chk("load_finished", fin, 1);
    cfg_valid = 0; rb_ready = 0; abort = 0; reset = 0;
    if (cut == 0) begin
      @(posedge clk); #1;
      chk("after_done", {done, busy, gin_hold}, 3'b000);
    end else begin
      repeat (4) begin
        @(posedge clk); #1;
        chk("idle_after_cut", {done, busy, se_id}, 3'b000);
      end
    end
  endtask

  initial begin
    logic [W-1:0] exp_w;
    reset = 1; start = 0; abort = 0; gin_idle = 1; cfg_valid = 0; rb_ready = 0;
    cfg_data = '0; seed_req = 1;
    for (int i = 0; i < CHAIN_LEN; i++) seed_val[i] = 1'($urandom_range(0, 1));
    repeat (3) @(posedge clk);
    #1;
    seed_req = 0;
    chk("reset_state", {busy, gin_hold, done, cfg_ready, rb_valid, se_id, si_id}, 7'd0);
    chk("reset_rb", rb_data, 0);
    reset = 0;
    @(posedge clk); #1;
    chk("idle_after_reset", {busy, gin_hold, done, cfg_ready, rb_valid, se_id}, 6'd0);

    // minimum-latency load with a fixed pattern
    for (int w = 0; w < NW; w++) words[w] = 32'hA5A5_0000 + w;
    run_load(0, -1, 0, 0, 0, 0);
    for (int w = 0; w < NW; w++) pat_a[w] = words[w];

    // second load with random data and random valid: readback must equal pattern A
    for (int w = 0; w < NW; w++) words[w] = $urandom();
    run_load(0, -1, 0, 1, 0, 0);
    for (int w = 0; w < NW; w++) begin
      exp_w = (w == NW-1) ? {{(W-LAST_BITS){1'b0}}, pat_a[w][LAST_BITS-1:0]} : pat_a[w];
      chk("readback_prev_load", rbw[w], exp_w);
    end

    // GIN not idle for 10 cycles after start
    for (int w = 0; w < NW; w++) words[w] = $urandom();
    run_load(10, -1, 0, 0, 0, 0);

    // readback backpressure on word 3
    for (int w = 0; w < NW; w++) words[w] = $urandom();
    run_load(0, 3, 7, 0, 0, 0);

    // reset mid-SHIFT of word 5, then a clean full load
    for (int w = 0; w < NW; w++) words[w] = $urandom();
    run_load(0, -1, 0, 0, 3, 5);
    run_load(2, -1, 0, 1, 0, 0);

    // abort in SHIFT, abort in RB, then a full load
    run_load(0, -1, 0, 0, 1, 2);
    run_load(0, -1, 0, 0, 2, 4);

    // start together with abort in IDLE: stays idle; abort alone in IDLE is harmless
    @(posedge clk); #1;
    start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    chk("start_abort_idle", {busy, gin_hold, cfg_ready}, 3'b000);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort_in_idle", {busy, gin_hold, done}, 3'b000);

    for (int w = 0; w < NW; w++) words[w] = $urandom();
    run_load(1, 10, 3, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
